// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, write-first bypass,
// optional hardwired-zero entry 0 and a clear sequencer that zeroes storage.
module regfile_mp #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic             ready;
    logic             wr_ok;

    // Address maps to real, writable storage (in range and not the zero entry).
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign ready = (state_q == StReady);
    assign busy  = (state_q == StClear);
    assign wr_ok = ready && wr_en && addr_live(wr_addr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (32'(cnt_q) == NUM_REGS - 1) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end
            end
            StReady: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage has no reset; the clear sequencer owns it while busy.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data_d;
        logic [DATA_W-1:0] data_q;
        logic              valid_q;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data_d = '0;
            if (addr_live(ra)) begin
                if (wr_ok && (wr_addr == ra)) begin
                    data_d = wr_data;
                end else begin
                    data_d = mem[ra[IDX_W-1:0]];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (ready && rd_en[k]) begin
                data_q  <= data_d;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data_q;
        assign rd_valid[k]                 = valid_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed steps plus random traffic
// checked every cycle against an array-based behavioural model.
module tb_regfile_mp;

    localparam int DW = 64;
    localparam int AW = 6;
    localparam int NR = 32;
    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NP-1:0]   rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]   rd_valid;
    logic            clr_req;
    logic            busy;

    int tests = 0;
    int fails = 0;

    // Model state: register contents, cycles of clear remaining, expected outputs.
    logic [DW-1:0] mdl [NR];
    int            clear_left;
    logic [DW-1:0] exp_data [NP];
    logic [NP-1:0] exp_valid;

    regfile_mp #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_REGS(NR),
        .NUM_RD  (NP),
        .ZERO_REG(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .clr_req (clr_req),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic wr_accepted();
        return (clear_left == 0) && wr_en && (int'(wr_addr) < NR) && (wr_addr != 0);
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        if (a >= NR || a == 0) return '0;
        if (wr_accepted() && int'(wr_addr) == a) return wr_data;
        return mdl[a];
    endfunction

    task automatic model_reset();
        clear_left = NR;
        exp_valid  = '0;
        for (int k = 0; k < NP; k++) exp_data[k] = '0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
    endtask

    task automatic model_edge();
        if (clear_left > 0) begin
            clear_left--;
            exp_valid = '0;
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (rd_en[k]) begin
                    exp_data[k]  = model_read(int'(rd_addr[k*AW +: AW]));
                    exp_valid[k] = 1'b1;
                end else begin
                    exp_valid[k] = 1'b0;
                end
            end
            if (wr_accepted()) mdl[wr_addr] = wr_data;
            // Entire array reads back zero once a clear completes.
            if (clr_req) begin
                clear_left = NR;
                for (int i = 0; i < NR; i++) mdl[i] = '0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("busy", DW'(busy), DW'(clear_left > 0));
        check("rd_valid", DW'(rd_valid), DW'(exp_valid));
        check("rd_data0", rd_data[0 +: DW], exp_data[0]);
        check("rd_data1", rd_data[DW +: DW], exp_data[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = '0;
        clr_req = 1'b0;
    endtask

    task automatic set_rd(input int p0, input int p1);
        rd_addr = {AW'(p1), AW'(p0)};
    endtask

    int bc;

    initial begin
        rst_n   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        idle();
        rd_en = 2'b11;
        set_rd(5, 31);
        model_reset();
        #12;
        compare_all();

        // Power-up clear: busy for exactly NR cycles, then zeroed contents.
        @(negedge clk) rst_n = 1'b1;
        bc = 0;
        for (int i = 0; i < NR + 1; i++) begin
            step();
            if (busy) bc++;
        end
        check("busy_cycles_powerup", DW'(bc + 1), DW'(NR));

        // Write then read on port 1.
        idle();
        wr_en = 1'b1; wr_addr = 7; wr_data = 64'hDEAD_BEEF_0123_4567;
        step();
        idle();
        rd_en = 2'b10; set_rd(0, 7);
        step();
        check("port1_read7", rd_data[DW +: DW], 64'hDEAD_BEEF_0123_4567);
        idle();
        step();

        // Write-first bypass, and the hardwired zero entry.
        wr_en = 1'b1; wr_addr = 3; wr_data = 64'hA5A5;
        rd_en = 2'b01; set_rd(3, 0);
        step();
        check("bypass3", rd_data[0 +: DW], 64'hA5A5);
        wr_addr = 0; wr_data = 64'hFF;
        rd_en = 2'b11; set_rd(0, 0);
        step();
        idle();
        rd_en = 2'b11; set_rd(0, 3);
        step();

        // Fill 1..4, then request a clear; writes during it are dropped.
        idle();
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
            step();
        end
        idle();
        rd_en = 2'b11; set_rd(1, 4);
        step();
        idle();
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 2; wr_data = 64'h77;
        rd_en = 2'b11; set_rd(2, 3);
        step();
        clr_req = 1'b0;
        bc = 0;
        for (int i = 0; i < NR; i++) begin
            wr_en = 1'b1; wr_addr = AW'($urandom_range(1, 4)); wr_data = {$urandom, $urandom};
            rd_en = NP'($urandom); set_rd($urandom_range(0, 4), $urandom_range(0, 4));
            step();
            if (busy) bc++;
        end
        check("busy_cycles_clrreq", DW'(bc + 1), DW'(NR));
        idle();
        for (int i = 1; i <= 4; i += 2) begin
            rd_en = 2'b11; set_rd(i, i + 1);
            step();
        end

        // Reset asserted at clear count 10 must restart the whole clear.
        idle();
        wr_en = 1'b1; wr_addr = 9; wr_data = 64'h1234;
        step();
        idle();
        rd_en = 2'b11; set_rd(9, 9);
        step();
        idle();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (10) step();
        #1 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        repeat (2) step();
        @(negedge clk) rst_n = 1'b1;
        bc = 0;
        for (int i = 0; i < NR + 1; i++) begin
            step();
            if (busy) bc++;
        end
        check("busy_cycles_midreset", DW'(bc + 1), DW'(NR));

        // Out-of-range address 40: write dropped, read returns zero.
        idle();
        wr_en = 1'b1; wr_addr = 40; wr_data = 64'hCAFE_F00D_CAFE_F00D;
        rd_en = 2'b11; set_rd(40, 8);
        step();
        idle();
        for (int i = 0; i < NR; i += 2) begin
            rd_en = 2'b11; set_rd(i, i + 1);
            step();
        end

        // Random traffic, addresses biased towards collisions.
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom);
            wr_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 9)) : AW'($urandom);
            wr_data = {$urandom, $urandom};
            rd_en   = NP'($urandom);
            set_rd(($urandom_range(0, 1) != 0) ? $urandom_range(0, 9) : $urandom_range(0, 63),
                   ($urandom_range(0, 1) != 0) ? $urandom_range(0, 9) : $urandom_range(0, 63));
            clr_req = ($urandom_range(0, 59) == 0);
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
